ofdm_cp_insert: RTL

- Downstream of the inverse-direction myFFT in the OFDM transmit chain.
- Captures each NFFT-sample IFFT output symbol into a ping-pong buffer.
- Re-emits each symbol as a cyclic prefix (last CP_LEN samples) followed by the full symbol, with a valid/ready stream on the output.
- Drives myFFT's flag_ready_recive, so the FFT stalls only while both banks are occupied.

---
 rtl/ofdm_cp_insert_pkg.sv | 19 +
 rtl/ofdm_cp_insert_pingpong_ram.sv | 32 +++
 rtl/ofdm_cp_insert.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ofdm_cp_insert_pkg.sv
// Shared definitions for the OFDM cyclic-prefix insertion/removal blocks.
// Holds the FSM encoding and the address helpers for the ping-pong buffer.
package ofdm_cp_insert_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OUT_CP   = 2'd1,
    OUT_BODY = 2'd2
  } cp_state_e;

  function automatic int nfft_of(input int size_buffer);
    return 1 << size_buffer;
  endfunction

  function automatic int cp_start_addr(input int size_buffer, input int cp_len);
    return nfft_of(size_buffer) - cp_len;
  endfunction

endpackage

// File: rtl/ofdm_cp_insert_pingpong_ram.sv
// Dual-rail (I/Q) 2*NFFT-word ping-pong buffer: one synchronous write port,
// one asynchronous read port. Also used by the CP-removal block.
module cp_pingpong_ram #(
  parameter int SIZE_BUFFER = 8,
  parameter int DATA_SIZE   = 16
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [SIZE_BUFFER:0]   waddr,
  input  logic [DATA_SIZE-1:0]   wdata_i,
  input  logic [DATA_SIZE-1:0]   wdata_q,
  input  logic [SIZE_BUFFER:0]   raddr,
  output logic [DATA_SIZE-1:0]   rdata_i,
  output logic [DATA_SIZE-1:0]   rdata_q
);

  localparam int DEPTH = 2 << SIZE_BUFFER;

  logic [DATA_SIZE-1:0] mem_i [DEPTH];
  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_i[waddr] <= wdata_i;
      mem_q[waddr] <= wdata_q;
    end
  end

  assign rdata_i = mem_i[raddr];
  assign rdata_q = mem_q[raddr];

endmodule

// File: rtl/ofdm_cp_insert.sv
// Captures IFFT output symbols into a ping-pong buffer and replays each one as
// cyclic prefix + full symbol on a valid/ready stream.
//
// state    | meaning
// IDLE     | no symbol being output; waits for the read bank to fill
// OUT_CP   | presenting the last CP_LEN samples of the symbol (the prefix)
// OUT_BODY | presenting samples 0..NFFT-1 of the symbol
module ofdm_cp_insert
  import ofdm_cp_insert_pkg::*;
#(
  parameter int SIZE_BUFFER = 8,
  parameter int DATA_SIZE   = 16,
  parameter int CP_LEN      = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] data_in_i,
  input  logic [DATA_SIZE-1:0] data_in_q,
  output logic                 ready_recive,
  output logic [DATA_SIZE-1:0] data_out_i,
  output logic [DATA_SIZE-1:0] data_out_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sym_start,
  output logic                 overflow
);

  localparam int NFFT = nfft_of(SIZE_BUFFER);
  localparam logic [SIZE_BUFFER-1:0] CP_START  = SIZE_BUFFER'(cp_start_addr(SIZE_BUFFER, CP_LEN));
  localparam logic [SIZE_BUFFER-1:0] LAST_ADDR = SIZE_BUFFER'(NFFT - 1);
  localparam logic [SIZE_BUFFER-1:0] ONE       = SIZE_BUFFER'(1);

  generate
    if (CP_LEN < 1 || CP_LEN > NFFT - 1) begin : g_bad_cp_len
      $error("ofdm_cp_insert: CP_LEN must be in 1..NFFT-1");
    end
  endgenerate

  logic [SIZE_BUFFER-1:0] wr_ptr;
  logic                   wr_bank;
  logic [1:0]             full;
  logic [1:0]             full_nxt;
  logic                   accept;
  logic                   wr_done;

  cp_state_e              state;
  logic [SIZE_BUFFER-1:0] rd_addr;
  logic                   rd_bank;
  logic [SIZE_BUFFER-1:0] ld_addr;
  logic                   ld_bank;
  logic                   rd_done;
  logic [DATA_SIZE-1:0]   rd_i;
  logic [DATA_SIZE-1:0]   rd_q;

  assign accept  = in_valid && ready_recive;
  assign wr_done = accept && (wr_ptr == LAST_ADDR);
  assign rd_done = out_valid && out_ready && (state == OUT_BODY) && (rd_addr == LAST_ADDR);

  // Release and fill always hit different banks, so both can land on one edge.
  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      wr_bank      <= 1'b0;
      full         <= 2'b00;
      ready_recive <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        wr_ptr <= wr_ptr + ONE;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      ready_recive <= !full_nxt[wr_done ? ~wr_bank : wr_bank];
      if (in_valid && !ready_recive) overflow <= 1'b1;
    end
  end

  // Address of the sample the FSM loads on its next output update.
  always_comb begin
    ld_bank = rd_bank;
    ld_addr = rd_addr + ONE;
    if (state == IDLE) begin
      ld_addr = CP_START;
    end else if (state == OUT_BODY && rd_addr == LAST_ADDR) begin
      ld_bank = ~rd_bank;
      ld_addr = CP_START;
    end
  end

  cp_pingpong_ram #(
    .SIZE_BUFFER (SIZE_BUFFER),
    .DATA_SIZE   (DATA_SIZE)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .waddr   ({wr_bank, wr_ptr}),
    .wdata_i (data_in_i),
    .wdata_q (data_in_q),
    .raddr   ({ld_bank, ld_addr}),
    .rdata_i (rd_i),
    .rdata_q (rd_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_addr    <= '0;
      rd_bank    <= 1'b0;
      out_valid  <= 1'b0;
      sym_start  <= 1'b0;
      data_out_i <= '0;
      data_out_q <= '0;
    end else if (!out_valid || out_ready) begin
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            rd_addr    <= ld_addr;
            data_out_i <= rd_i;
            data_out_q <= rd_q;
            out_valid  <= 1'b1;
            sym_start  <= 1'b1;
            state      <= OUT_CP;
          end
        end
        OUT_CP: begin
          rd_addr    <= ld_addr;
          data_out_i <= rd_i;
          data_out_q <= rd_q;
          sym_start  <= 1'b0;
          if (rd_addr == LAST_ADDR) state <= OUT_BODY;
        end
        OUT_BODY: begin
          if (rd_addr == LAST_ADDR) begin
            rd_bank <= ~rd_bank;
            if (full[~rd_bank]) begin
              rd_addr    <= ld_addr;
              data_out_i <= rd_i;
              data_out_q <= rd_q;
              sym_start  <= 1'b1;
              state      <= OUT_CP;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            rd_addr    <= ld_addr;
            data_out_i <= rd_i;
            data_out_q <= rd_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
